// File: rtl/axi_lite_pkg.sv
// axi_lite_pkg: shared state encoding and constants for the AXI4-Lite read master.
package axi_lite_pkg;
   typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;
   localparam int DATA_W = 32;
   localparam logic [1:0] ALIGN_MASK = 2'b11;
   localparam logic [DATA_W-1:0] ERR_DATA = 32'h0;
   function automatic logic word_aligned(input logic [1:0] lsb);
      return (lsb & ALIGN_MASK) == 2'b00;
   endfunction
endpackage

// File: rtl/rsp_hold_reg.sv
// rsp_hold_reg: one-entry response buffer, holds data/err until the core takes it.
module rsp_hold_reg
   import axi_lite_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_load,
   input  logic [DATA_W-1:0] i_data,
   input  logic              i_err,
   input  logic              i_ready,
   output logic              o_valid,
   output logic [DATA_W-1:0] o_data,
   output logic              o_err
);
   logic              r_valid;
   logic [DATA_W-1:0] r_data;
   logic              r_err;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_data  <= '0;
         r_err   <= 1'b0;
      end else if (i_load) begin
         r_valid <= 1'b1;
         r_data  <= i_data;
         r_err   <= i_err;
      end else if (r_valid && i_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign o_valid = r_valid;
   assign o_data  = r_data;
   assign o_err   = r_err;
endmodule

// File: rtl/axi_lite_rd_master.sv
// axi_lite_rd_master: single-outstanding AXI4-Lite read initiator with local
// misalignment rejection and a sticky bus-stall watchdog.
module axi_lite_rd_master
   import axi_lite_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 256
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   input  logic [ADDR_W-1:0] req_addr,
   output logic              req_ready,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_err,
   input  logic              rsp_ready,
   output logic [ADDR_W-1:0] m_araddr,
   output logic              m_arvalid,
   input  logic              m_arready,
   input  logic [DATA_W-1:0] m_rdata,
   input  logic              m_rvalid,
   output logic              m_rready,
   output logic              timeout,
   output logic              busy
);
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] WD_MAX = CNT_W'(TIMEOUT);

   state_t            r_state;
   logic              r_req_ready;
   logic              r_busy;
   logic              r_arvalid;
   logic [ADDR_W-1:0] r_araddr;
   logic [CNT_W-1:0]  r_wd_cnt;
   logic              r_timeout;
   logic              w_accept;
   logic              w_misaligned;
   logic              w_rsp_load;
   logic              w_rsp_err;
   logic [DATA_W-1:0] w_rsp_data;
   logic              w_on_bus;

   assign w_accept     = (r_state == IDLE) && r_req_ready && req_valid;
   assign w_misaligned = !word_aligned(req_addr[1:0]);
   // Slaves drop rvalid on seeing rready, so rready only ever follows rvalid.
   assign m_rready     = m_rvalid && (r_state == DATA);
   assign w_rsp_load   = (w_accept && w_misaligned) || m_rready;
   assign w_rsp_data   = m_rready ? m_rdata : ERR_DATA;
   assign w_rsp_err    = !m_rready;
   assign w_on_bus     = (r_state == ADDR) || (r_state == DATA);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_req_ready <= 1'b0;
         r_busy      <= 1'b0;
         r_arvalid   <= 1'b0;
         r_araddr    <= '0;
         r_wd_cnt    <= '0;
         r_timeout   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_req_ready <= 1'b1;
               if (w_accept) begin
                  r_req_ready <= 1'b0;
                  r_busy      <= 1'b1;
                  if (w_misaligned) begin
                     r_state <= RESP;
                  end else begin
                     r_state   <= ADDR;
                     r_araddr  <= req_addr;
                     r_arvalid <= 1'b1;
                     r_wd_cnt  <= '0;
                  end
               end
            end
            ADDR: if (m_arready) begin
               r_arvalid <= 1'b0;
               r_state   <= DATA;
            end
            DATA: if (m_rvalid) r_state <= RESP;
            RESP: if (rsp_ready) begin
               r_state     <= IDLE;
               r_req_ready <= 1'b1;
               r_busy      <= 1'b0;
            end
            default: begin
               r_state     <= IDLE;
               r_req_ready <= 1'b0;
               r_busy      <= 1'b0;
               r_arvalid   <= 1'b0;
            end
         endcase
         // Watchdog only flags the stall; the transaction keeps waiting.
         if (w_on_bus && r_wd_cnt != WD_MAX) begin
            r_wd_cnt <= r_wd_cnt + CNT_W'(1);
            if (r_wd_cnt + CNT_W'(1) == WD_MAX) r_timeout <= 1'b1;
         end
      end
   end

   rsp_hold_reg u_rsp (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_load  (w_rsp_load),
      .i_data  (w_rsp_data),
      .i_err   (w_rsp_err),
      .i_ready (rsp_ready),
      .o_valid (rsp_valid),
      .o_data  (rsp_data),
      .o_err   (rsp_err)
   );

   assign req_ready = r_req_ready;
   assign busy      = r_busy;
   assign m_arvalid = r_arvalid;
   assign m_araddr  = r_araddr;
   assign timeout   = r_timeout;
endmodule

// File: tb/tb_axi_lite_rd_master.sv
// tb_axi_lite_rd_master: randomized scoreboard bench with a transaction-level
// reference model and a behavioural ROM slave.
module tb_axi_lite_rd_master;
   localparam int ADDR_W = 32;
   localparam int TO     = 8;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              req_valid = 1'b0;
   logic [ADDR_W-1:0] req_addr = '0;
   logic              rsp_ready = 1'b0;
   logic              m_arready = 1'b0;
   logic [31:0]       m_rdata = '0;
   logic              m_rvalid = 1'b0;
   logic              req_ready, rsp_valid, rsp_err, m_arvalid, m_rready, timeout, busy;
   logic [31:0]       rsp_data;
   logic [ADDR_W-1:0] m_araddr;

   always #5 clk = ~clk;

   axi_lite_rd_master #(.ADDR_W(ADDR_W), .TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
      .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
      .rsp_err(rsp_err), .rsp_ready(rsp_ready), .m_araddr(m_araddr),
      .m_arvalid(m_arvalid), .m_arready(m_arready), .m_rdata(m_rdata),
      .m_rvalid(m_rvalid), .m_rready(m_rready), .timeout(timeout), .busy(busy)
   );

   typedef struct packed {logic [31:0] data; logic err;} rsp_t;
   rsp_t              exp_q[$];
   logic [ADDR_W-1:0] addr_q[$];
   logic [31:0]       mem[64];
   int                checks = 0, failures = 0;
   int                ar_lo = 0, ar_hi = 0, r_lo = 0, r_hi = 0, rsp_gap = 0;
   bit                stall = 0, spur = 0, rsp_tie = 1;
   bit                outst, in_bus, ar_ph, started, exp_to;
   int                bus_cyc;
   logic [31:0]       last_rsp = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic bound_fail(input string name);
      checks++;
      failures++;
      $display("FAIL %s: wait bound expired at %0t", name, $time);
   endtask

   function automatic void clear_model();
      outst = 0; in_bus = 0; ar_ph = 0; started = 0; exp_to = 0; bus_cyc = 0;
      exp_q.delete();
      addr_q.delete();
   endfunction

   // Reference model: tracks the transaction lifecycle and checks outputs mid-cycle.
   initial begin
      bit f_acc, f_ar, f_r, f_rsp;
      logic [ADDR_W-1:0] a;
      clear_model();
      forever begin
         @(negedge clk);
         f_acc = 0; f_ar = 0; f_r = 0; f_rsp = 0; a = req_addr;
         if (!rst_n) begin
            clear_model();
            chk("reset_outputs", {req_ready, rsp_valid, rsp_err, m_arvalid, m_rready,
                                  timeout, busy, |rsp_data, |m_araddr}, 0);
         end else begin
            chk("req_ready", req_ready, started && !outst);
            chk("busy", busy, outst);
            chk("rsp_valid", rsp_valid, outst && !in_bus);
            chk("m_arvalid", m_arvalid, ar_ph);
            chk("m_rready", m_rready, in_bus && !ar_ph && m_rvalid);
            chk("timeout", timeout, exp_to);
            if (ar_ph) chk("m_araddr", m_araddr, addr_q[0]);
            if (outst && !in_bus) begin
               chk("rsp_data", rsp_data, exp_q[0].data);
               chk("rsp_err", rsp_err, exp_q[0].err);
            end
            f_acc = req_valid && started && !outst;
            f_ar  = ar_ph && m_arready;
            f_r   = in_bus && !ar_ph && m_rvalid;
            f_rsp = outst && !in_bus && rsp_ready;
            if (f_rsp) last_rsp = rsp_data;
         end
         @(posedge clk);
         if (!rst_n) clear_model();
         else begin
            if (in_bus) begin
               bus_cyc++;
               if (bus_cyc >= TO) exp_to = 1;
            end
            if (f_rsp) begin exp_q.delete(0); outst = 0; end
            if (f_ar) begin addr_q.delete(0); ar_ph = 0; end
            if (f_r) in_bus = 0;
            if (f_acc) begin
               outst = 1;
               if (a[1:0] != 2'b00) exp_q.push_back({32'h0, 1'b1});
               else begin
                  exp_q.push_back({mem[a[7:2]], 1'b0});
                  addr_q.push_back(a);
                  in_bus = 1; ar_ph = 1; bus_cyc = 0;
               end
            end
            started = 1;
         end
      end
   end

   // ROM slave: configurable AR/R latency, optional stall and stray handshakes.
   initial begin
      bit s_ar, s_r, pending, armed;
      logic [ADDR_W-1:0] s_addr, paddr;
      int ar_wait, r_wait;
      pending = 0; armed = 0; ar_wait = 0; r_wait = 0; paddr = '0;
      forever begin
         @(posedge clk);
         s_ar = m_arvalid && m_arready; s_r = m_rvalid && m_rready; s_addr = m_araddr;
         #1;
         if (!rst_n) begin
            m_arready = 0; m_rvalid = 0; pending = 0; armed = 0;
         end else begin
            if (s_r) begin m_rvalid = 0; pending = 0; end
            if (s_ar) begin
               pending = 1; paddr = s_addr; armed = 0; m_arready = 0; m_rvalid = 0;
               r_wait = $urandom_range(r_hi, r_lo);
            end else if (m_arvalid) begin
               if (!armed) begin armed = 1; ar_wait = $urandom_range(ar_hi, ar_lo); end
               m_arready = (ar_wait == 0);
               if (ar_wait > 0) ar_wait--;
            end else m_arready = spur && ($urandom_range(0, 3) == 0);
            if (pending && !stall) begin
               if (r_wait == 0) begin m_rvalid = 1; m_rdata = mem[paddr[7:2]]; end
               else r_wait--;
            end else if (!pending) begin
               m_rvalid = spur && ($urandom_range(0, 3) == 0);
               m_rdata = $urandom;
            end
         end
      end
   end

   initial begin
      int hold_cnt;
      hold_cnt = 0;
      forever begin
         @(posedge clk);
         #1;
         hold_cnt = rsp_valid ? hold_cnt + 1 : 0;
         rsp_ready = rsp_tie ? 1'b1 : (rsp_gap > 0) ? (hold_cnt > rsp_gap)
                                                    : ($urandom_range(0, 3) != 0);
      end
   end

   task automatic step(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic issue(input logic [ADDR_W-1:0] a);
      bit ok;
      int n;
      ok = 0; n = 0;
      req_valid = 1; req_addr = a;
      do begin
         @(negedge clk);
         ok = req_ready;
         @(posedge clk);
         #1;
         n++;
      end while (!ok && n < 400);
      req_valid = 0; req_addr = $urandom;
      if (!ok) bound_fail("issue");
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((outst || exp_q.size() != 0) && n < 400) begin step(1); n++; end
      if (n >= 400) bound_fail("drain");
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1 rst_n = 0;
      repeat (2) @(negedge clk);
      #1 rst_n = 1;
      step(1);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout at %0t", $time);
      $fatal(1, "bench did not terminate");
   end

   initial begin
      logic [ADDR_W-1:0] a;
      int n;
      for (int i = 0; i < 64; i++) mem[i] = $urandom;
      mem[4] = 32'hDEAD_BEEF;
      repeat (3) @(negedge clk);
      #1 rst_n = 1;
      step(1);
      issue(32'h0000_0010); drain();
      chk("rom_word", last_rsp, 32'hDEAD_BEEF);
      issue(32'h0000_0006); drain();
      chk("misaligned_data", last_rsp, 32'h0);
      ar_lo = 5; ar_hi = 5; rsp_tie = 0; rsp_gap = 3;
      issue(32'h0000_0020); drain();
      chk("backpressure_word", last_rsp, mem[8]);
      ar_lo = 0; ar_hi = 0; rsp_tie = 1; rsp_gap = 0;
      issue(32'h0); issue(32'h4); issue(32'h8); drain();
      chk("b2b_last", last_rsp, mem[2]);
      spur = 1; ar_hi = 3; r_hi = 3; rsp_tie = 0;
      for (int i = 0; i < 40; i++) begin
         a = $urandom & 32'hFFFF_FF00;
         a[7:2] = 6'($urandom_range(0, 63));
         a[1:0] = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         issue(a);
         step($urandom_range(0, 2));
      end
      drain();
      spur = 0; ar_hi = 0; r_hi = 0; rsp_tie = 1;
      do_reset();
      stall = 1;
      issue(32'h0000_0040);
      step(12);
      chk("wd_busy", busy, 1);
      chk("wd_timeout", timeout, 1);
      stall = 0; drain();
      chk("wd_sticky", timeout, 1);
      chk("wd_data", last_rsp, mem[16]);
      stall = 1;
      issue(32'h0000_0008);
      n = 0;
      while (!(in_bus && !ar_ph) && n < 50) begin step(1); n++; end
      if (n >= 50) bound_fail("reach_data");
      @(posedge clk);
      #3 rst_n = 0;
      #1 chk("rst_async", {req_ready, rsp_valid, rsp_err, m_arvalid, m_rready,
                           timeout, busy, |rsp_data, |m_araddr}, 0);
      stall = 0;
      repeat (2) @(negedge clk);
      #1 rst_n = 1;
      step(1);
      issue(32'h0); drain();
      chk("post_reset_word", last_rsp, mem[0]);
      step(2);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/axi_lite_rd_master.md
# axi_lite_rd_master

AXI4-Lite read-only initiator that sits between a core-side fetch/load port and an AXI4-Lite read slave (the boot ROM and other read-only memories on the fabric). It accepts one word request at a time from the core, runs a single AR/R transaction on the bus, and returns the data through a one-entry response buffer with a valid/ready handshake. It also rejects misaligned requests locally and flags bus stalls with a watchdog.

## Interface
- ADDR_W, 32, address width of core request and m_araddr
- TIMEOUT, 256, watchdog limit in cycles per transaction (≥2)
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  core request valid
- req_addr  in  ADDR_W  byte address of requested word
- req_ready  out  1  request accepted when req_valid & req_ready
- rsp_valid  out  1  response valid
- rsp_data  out  32  read data (0 on error)
- rsp_err  out  1  1 = misaligned request (no bus access made)
- rsp_ready  in  1  core accepts response
- m_araddr  out  ADDR_W  AXI read address
- m_arvalid  out  1  AXI address valid
- m_arready  in  1  AXI address ready
- m_rdata  in  32  AXI read data
- m_rvalid  in  1  AXI read data valid
- m_rready  out  1  AXI read data ready
- timeout  out  1  sticky watchdog flag
- busy  out  1  state ≠ IDLE

## Operation
- States: IDLE, ADDR, DATA, RESP.
- IDLE: req_ready=1. On req_valid:
  - if req_addr[1:0]≠0: load buffer with rsp_data=0, rsp_err=1; go RESP.
  - else latch addr into m_araddr, m_arvalid←1; go ADDR.
- ADDR: hold m_arvalid=1 and m_araddr stable until m_arready sampled high. Then m_arvalid←0; go DATA.
- DATA: m_rready = m_rvalid & (state==DATA), combinational. m_rready is never asserted before m_rvalid. This is required because the attached slaves drop rvalid in the same cycle they see rready. On m_rvalid: capture m_rdata, set rsp_err=0; go RESP.
- RESP: rsp_valid=1, with rsp_data/rsp_err held stable. On rsp_ready: rsp_valid←0; go IDLE.
- One outstanding transaction only. req_ready=0 in ADDR, DATA and RESP.
- Watchdog:
  - Counter clears on entry to ADDR and increments each cycle in ADDR or DATA.
  - When the count reaches TIMEOUT, timeout←1. It stays set until reset.
  - The transaction is not aborted; the master keeps waiting for the bus.
  - The counter saturates at TIMEOUT.
- Unknown state encodings recover to IDLE.

## Timing
- Reset values: req_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0, m_araddr=0, m_arvalid=0, m_rready=0, timeout=0, busy=0. req_ready rises in the first cycle after reset release.
- Request accept (edge N) → m_arvalid high from cycle N+1.
- m_arready at edge A → m_arvalid low at A+1, state DATA at A+1.
- m_rvalid sampled at edge R (m_rready high in that same cycle) → rsp_valid high at R+1.
- Misaligned request accepted at N → rsp_valid, rsp_err high at N+1.
- rsp_ready at edge K → req_ready high at K+1. No same-cycle turnaround. Minimum aligned request-to-request period is 4 cycles plus slave latency.
- m_arready high while m_arvalid is low: ignored.
- m_rvalid outside DATA: ignored, m_rready stays 0.
- Reset mid-transaction: all outputs return to their reset values immediately (asynchronous). The bus side relies on the slave sharing rst_n.

## Structure
- Shared package axi_lite_pkg: state enum (IDLE/ADDR/DATA/RESP), alignment mask constant, error-data constant 32'h0.
- The single-entry response buffer (data, err, valid with hold-until-ready) is a natural sub-module, rsp_hold_reg. The FSM and watchdog stay in the top module.

## Test plan
- Aligned read, ROM-style slave (arready registered, rvalid 1 cycle after AR): req_addr=0x0000_0010, word 4 = 0xDEAD_BEEF → m_araddr=0x10, rsp_data=0xDEAD_BEEF, rsp_err=0. m_rready high only in the cycle m_rvalid is high.
- Misaligned request req_addr=0x0000_0006 → rsp_err=1, rsp_data=0 one cycle after accept. m_arvalid never asserted.
- Backpressure on both sides:
  - slave holds arready low 5 cycles → m_arvalid/m_araddr stable throughout.
  - rsp_ready low 3 cycles → rsp_valid/rsp_data stable, req_ready stays 0.
- Watchdog with TIMEOUT=8: slave never returns rvalid → timeout=1 after 8 cycles in ADDR/DATA, busy stays 1. A later rvalid completes normally and timeout remains 1.
- Back-to-back reads 0x0, 0x4, 0x8 with rsp_ready tied 1 → three responses in order with correct data. req_ready high exactly one cycle after each response handshake.
- Assert rst_n low while in DATA → all outputs at reset values in the same cycle. After release, a fresh read to 0x0 completes correctly.
